// File: rtl/spi_reg_master.sv
// -----------------------------------------------------------------------------
// spi_reg_master
//
// SPI register-access master for the sensor control path. Issues single or
// burst register reads and writes. A frame is one control bit (1 = write,
// 0 = read), an MSB-first address, then N MSB-first data words, where
// N = max(len, 1). SPI_CLK idles low; the master changes SPI_IN on the edge
// that enters the low phase, and samples SPI_OUT on the edge that drives
// SPI_CLK high.
//
// Parameters
//   ADDR_W   address bits per frame
//   DATA_W   bits per data word
//   CLK_DIV  FSM_Clk cycles per SPI_CLK half-period (>= 1)
//   LEN_W    width of the burst length input
//
// Ports
//   FSM_Clk      system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   start        frame request, sampled only in IDLE
//   rw           1 = write, 0 = read
//   addr         register address
//   len          burst length in words (0 is treated as 1)
//   wdata        write word
//   wdata_ack    one-cycle pulse when wdata is latched
//   rdata        last completed read word
//   rdata_valid  one-cycle pulse when rdata is updated
//   busy         high from the accept edge until the IDLE return edge
//   done         one-cycle pulse at frame end
//   SPI_EN       chip enable, active-high
//   SPI_CLK      serial clock, idle low
//   SPI_IN       serial data to the slave, 0 when not driven
//   SPI_IN_OE    high while the master drives SPI_IN
//   SPI_OUT      serial data from the slave
// -----------------------------------------------------------------------------
module spi_reg_master #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 1,
  parameter int LEN_W   = 4
) (
  input  logic              FSM_Clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              SPI_EN,
  output logic              SPI_CLK,
  output logic              SPI_IN,
  output logic              SPI_IN_OE,
  input  logic              SPI_OUT
);

  // Bit counter sized for the longest frame (all-ones len) plus one spare
  // count, so the index never wraps inside a frame.
  localparam int BIT_W = $clog2(1 + ADDR_W + ((1 << LEN_W) - 1) * DATA_W + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WB_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_TRAIL
  } state_t;

  // Registered state
  state_t              r_state;
  logic [DIV_W-1:0]    r_div_cnt;   // cycles spent in the current half-period
  logic [BIT_W-1:0]    r_bit_idx;   // index of the bit on the wire, 0 = control
  logic [BIT_W-1:0]    r_nb;        // total bits in this frame
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr_sh;   // address, shifted out MSB first
  logic [DATA_W-1:0]   r_tx_sh;     // write word, shifted out MSB first
  logic [DATA_W-2:0]   r_rx_sh;     // read bits collected so far in this word
  logic [WB_W-1:0]     r_wbit;      // position of the current data bit in its word
  logic                r_spi_en;
  logic                r_spi_clk;
  logic                r_spi_in;
  logic                r_spi_oe;
  logic                r_busy;
  logic                r_done;
  logic                r_wdata_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rdata_valid;

  // Next-state values
  state_t              w_state_nxt;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [BIT_W-1:0]    w_nb_nxt;
  logic                w_rw_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_tx_nxt;
  logic [DATA_W-2:0]   w_rx_nxt;
  logic [WB_W-1:0]     w_wbit_nxt;
  logic                w_en_nxt;
  logic                w_clk_nxt;
  logic                w_in_nxt;
  logic                w_oe_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_ack_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_rvalid_nxt;

  // Helpers
  logic [LEN_W-1:0]    w_len_eff;
  logic [BIT_W-1:0]    w_nb;
  logic                w_div_end;
  logic                w_cur_data;
  logic                w_last_bit;
  logic                w_word_end;
  logic                w_reload;
  logic [DATA_W-1:0]   w_tx_src;
  logic [DATA_W-1:0]   w_rx_word;

  assign w_len_eff  = (len == '0) ? LEN_W'(1) : len;
  assign w_nb       = BIT_W'(1 + ADDR_W) + BIT_W'(w_len_eff) * BIT_W'(DATA_W);
  assign w_div_end  = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_cur_data = (r_bit_idx > BIT_W'(ADDR_W));
  assign w_last_bit = (r_bit_idx == r_nb - BIT_W'(1));
  assign w_word_end = (r_wbit == WB_W'(DATA_W - 1));
  assign w_rx_word  = {r_rx_sh, SPI_OUT};

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div_cnt;
    w_bit_nxt    = r_bit_idx;
    w_nb_nxt     = r_nb;
    w_rw_nxt     = r_rw;
    w_addr_nxt   = r_addr_sh;
    w_tx_nxt     = r_tx_sh;
    w_rx_nxt     = r_rx_sh;
    w_wbit_nxt   = r_wbit;
    w_en_nxt     = r_spi_en;
    w_clk_nxt    = r_spi_clk;
    w_in_nxt     = r_spi_in;
    w_oe_nxt     = r_spi_oe;
    w_busy_nxt   = r_busy;
    w_rdata_nxt  = r_rdata;
    w_done_nxt   = 1'b0;
    w_ack_nxt    = 1'b0;
    w_rvalid_nxt = 1'b0;
    w_reload     = 1'b0;
    w_tx_src     = r_tx_sh;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOW;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_wbit_nxt  = '0;
          w_nb_nxt    = w_nb;
          w_rw_nxt    = rw;
          w_addr_nxt  = addr;
          w_tx_nxt    = rw ? wdata : r_tx_sh;
          w_ack_nxt   = rw;
          w_en_nxt    = 1'b1;
          w_clk_nxt   = 1'b0;
          w_in_nxt    = rw;          // control bit goes out first
          w_oe_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end

      S_LOW: begin
        if (w_div_end) begin
          w_state_nxt = S_HIGH;
          w_div_nxt   = '0;
          w_clk_nxt   = 1'b1;
          // Read data is sampled on the edge that raises SPI_CLK; the
          // completed word is presented in the following cycle.
          if (w_cur_data && !r_rw) begin
            w_rx_nxt = w_rx_word[DATA_W-2:0];
            if (w_word_end) begin
              w_rdata_nxt  = w_rx_word;
              w_rvalid_nxt = 1'b1;
            end
          end
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      S_HIGH: begin
        if (w_div_end) begin
          w_div_nxt = '0;
          w_clk_nxt = 1'b0;
          if (w_last_bit) begin
            w_state_nxt = S_TRAIL;
            w_in_nxt    = 1'b0;
            w_oe_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_LOW;
            w_bit_nxt   = r_bit_idx + BIT_W'(1);
            if (r_bit_idx < BIT_W'(ADDR_W)) begin
              // Next bit is an address bit.
              w_in_nxt   = r_addr_sh[ADDR_W-1];
              w_oe_nxt   = 1'b1;
              w_addr_nxt = {r_addr_sh[ADDR_W-2:0], 1'b0};
            end else begin
              // Next bit is a data bit. Word 0 was latched at accept; later
              // words are fetched from wdata as their first bit goes out.
              if (r_bit_idx == BIT_W'(ADDR_W)) begin
                w_wbit_nxt = '0;
              end else if (w_word_end) begin
                w_wbit_nxt = '0;
                w_reload   = r_rw;
              end else begin
                w_wbit_nxt = r_wbit + WB_W'(1);
              end
              w_tx_src = w_reload ? wdata : r_tx_sh;
              if (r_rw) begin
                w_in_nxt  = w_tx_src[DATA_W-1];
                w_oe_nxt  = 1'b1;
                w_tx_nxt  = {w_tx_src[DATA_W-2:0], 1'b0};
                w_ack_nxt = w_reload;
              end else begin
                w_in_nxt = 1'b0;
                w_oe_nxt = 1'b0;
              end
            end
          end
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      S_TRAIL: begin
        w_state_nxt = S_IDLE;
        w_en_nxt    = 1'b0;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the values from before the clock edge. Every register, including
  // the datapath, is cleared by reset: the outputs must read 0 while rst_n
  // is low and an interrupted frame must leave nothing behind.
  always_ff @(posedge FSM_Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_div_cnt     <= '0;
      r_bit_idx     <= '0;
      r_nb          <= '0;
      r_rw          <= 1'b0;
      r_addr_sh     <= '0;
      r_tx_sh       <= '0;
      r_rx_sh       <= '0;
      r_wbit        <= '0;
      r_spi_en      <= 1'b0;
      r_spi_clk     <= 1'b0;
      r_spi_in      <= 1'b0;
      r_spi_oe      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_wdata_ack   <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_div_cnt     <= w_div_nxt;
      r_bit_idx     <= w_bit_nxt;
      r_nb          <= w_nb_nxt;
      r_rw          <= w_rw_nxt;
      r_addr_sh     <= w_addr_nxt;
      r_tx_sh       <= w_tx_nxt;
      r_rx_sh       <= w_rx_nxt;
      r_wbit        <= w_wbit_nxt;
      r_spi_en      <= w_en_nxt;
      r_spi_clk     <= w_clk_nxt;
      r_spi_in      <= w_in_nxt;
      r_spi_oe      <= w_oe_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_wdata_ack   <= w_ack_nxt;
      r_rdata       <= w_rdata_nxt;
      r_rdata_valid <= w_rvalid_nxt;
    end
  end

  assign wdata_ack   = r_wdata_ack;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign SPI_EN      = r_spi_en;
  assign SPI_CLK     = r_spi_clk;
  assign SPI_IN      = r_spi_in;
  assign SPI_IN_OE   = r_spi_oe;

endmodule

// File: tb/tb_spi_reg_master.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_master
//
// Self-checking bench for spi_reg_master. One instance uses the default
// parameters, a second uses CLK_DIV=3. Each instance has a small slave model
// that shifts its words out on SPI_CLK falling edges after the address.
// Table-driven frames cover single/burst reads and writes; hand-written
// sequences cover ignored starts, back-to-back frames, reset mid-frame and
// the slow-clock instance.
// -----------------------------------------------------------------------------
module tb_spi_reg_master;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       start  = 1'b0;
  logic       start3 = 1'b0;
  logic       rw     = 1'b0;
  logic [6:0] addr   = '0;
  logic [3:0] len    = '0;
  logic [7:0] wdata  = '0;

  logic       wdata_ack, rdata_valid, busy, done;
  logic [7:0] rdata;
  logic       spi_en, spi_clk, spi_in, spi_oe;
  logic       spi_out = 1'b0;

  logic       wdata_ack3, rdata_valid3, busy3, done3;
  logic [7:0] rdata3;
  logic       spi_en3, spi_clk3, spi_in3, spi_oe3;
  logic       spi_out3 = 1'b0;

  always #5 clk = ~clk;

  spi_reg_master u_dut (
    .FSM_Clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr),
    .len(len), .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done), .SPI_EN(spi_en),
    .SPI_CLK(spi_clk), .SPI_IN(spi_in), .SPI_IN_OE(spi_oe), .SPI_OUT(spi_out)
  );

  spi_reg_master #(.CLK_DIV(3)) u_dut3 (
    .FSM_Clk(clk), .rst_n(rst_n), .start(start3), .rw(rw), .addr(addr),
    .len(len), .wdata(wdata), .wdata_ack(wdata_ack3), .rdata(rdata3),
    .rdata_valid(rdata_valid3), .busy(busy3), .done(done3), .SPI_EN(spi_en3),
    .SPI_CLK(spi_clk3), .SPI_IN(spi_in3), .SPI_IN_OE(spi_oe3), .SPI_OUT(spi_out3)
  );

  // Slave models: count SPI_CLK rises; after control + 7 address bits,
  // present data bits on each falling edge.
  logic [7:0] s_words  [0:3];
  logic [7:0] s3_words [0:3];
  int s_cnt  = 0;
  int s3_cnt = 0;

  always @(posedge spi_clk or negedge spi_en)
    if (!spi_en) s_cnt <= 0; else s_cnt <= s_cnt + 1;

  always @(negedge spi_clk or negedge spi_en)
    if (!spi_en) spi_out <= 1'b0;
    else if (s_cnt >= 8 && s_cnt < 40) spi_out <= s_words[(s_cnt-8)/8][7-((s_cnt-8)%8)];

  always @(posedge spi_clk3 or negedge spi_en3)
    if (!spi_en3) s3_cnt <= 0; else s3_cnt <= s3_cnt + 1;

  always @(negedge spi_clk3 or negedge spi_en3)
    if (!spi_en3) spi_out3 <= 1'b0;
    else if (s3_cnt >= 8 && s3_cnt < 40) spi_out3 <= s3_words[(s3_cnt-8)/8][7-((s3_cnt-8)%8)];

  // Monitor, sampled on the falling FSM_Clk edge.
  int          m_cyc = 0, m_pulses = 0, m_acks = 0, m_dones = 0, m_done_cyc = 0;
  int          m3_dones = 0, m3_done_cyc = 0, m3_rv = 0;
  logic        m_prev = 1'b0;
  logic [63:0] m_bits = '0, m_oe = '0;
  logic [7:0]  m_rv_val [$];
  int          m_rv_cyc [$];

  always @(negedge clk) begin
    m_cyc  <= m_cyc + 1;
    m_prev <= spi_clk;
    if (spi_clk && !m_prev) begin
      m_pulses <= m_pulses + 1;
      m_bits   <= {m_bits[62:0], spi_in};
      m_oe     <= {m_oe[62:0], spi_oe};
    end
    if (wdata_ack) m_acks <= m_acks + 1;
    if (rdata_valid) begin
      m_rv_val.push_back(rdata);
      m_rv_cyc.push_back(m_cyc);
    end
    if (done) begin
      m_dones    <= m_dones + 1;
      m_done_cyc <= m_cyc;
    end
    if (done3) begin
      m3_dones    <= m3_dones + 1;
      m3_done_cyc <= m_cyc;
    end
    if (rdata_valid3) m3_rv <= m3_rv + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input bit is3, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (is3 ? done3 : done) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(ok), 64'd1);
  endtask

  typedef struct packed {
    logic        rw;
    logic [6:0]  addr;
    logic [3:0]  len;
    logic [7:0]  w0;      // wdata at accept
    logic [7:0]  w1;      // wdata presented after accept
    logic [23:0] sw;      // slave words 0,1,2
    int          nb;      // expected SPI_CLK pulses
    int          lat;     // expected accept-to-done cycles
    int          acks;
    int          nrv;
    logic [63:0] bits;    // expected SPI_IN at rises, last bit at LSB
    logic [63:0] oe;      // expected SPI_IN_OE at rises
    logic [7:0]  rdata;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int p0, a0, d0, r0, acc;
    bit ok;
    logic [63:0] mask;
    logic [7:0]  exp_w;
    s_words[0] = v.sw[23:16];
    s_words[1] = v.sw[15:8];
    s_words[2] = v.sw[7:0];
    @(negedge clk);
    rw = v.rw; addr = v.addr; len = v.len; wdata = v.w0; start = 1'b1;
    #1;
    p0 = m_pulses; a0 = m_acks; d0 = m_dones; r0 = m_rv_val.size();
    @(posedge clk);
    #1;
    acc = m_cyc;
    start = 1'b0; rw = ~v.rw; addr = ~v.addr; len = '0; wdata = v.w1;
    wait_done(1'b0, tag, ok);
    #1;
    mask = (64'd1 << v.nb) - 64'd1;
    check({tag, "_latency"}, 64'(m_done_cyc - acc), 64'(v.lat));
    check({tag, "_pulses"}, 64'(m_pulses - p0), 64'(v.nb));
    check({tag, "_spi_in"}, m_bits & mask, v.bits);
    check({tag, "_spi_oe"}, m_oe & mask, v.oe);
    check({tag, "_acks"}, 64'(m_acks - a0), 64'(v.acks));
    check({tag, "_dones"}, 64'(m_dones - d0), 64'd1);
    check({tag, "_rvalids"}, 64'(m_rv_val.size() - r0), 64'(v.nrv));
    check({tag, "_rdata"}, 64'(rdata), 64'(v.rdata));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    for (int k = 0; k < v.nrv && r0 + k < m_rv_val.size(); k++) begin
      exp_w = (k == 0) ? v.sw[23:16] : (k == 1) ? v.sw[15:8] : v.sw[7:0];
      check($sformatf("%s_rword%0d", tag, k), 64'(m_rv_val[r0+k]), 64'(exp_w));
      if (k > 0)
        check($sformatf("%s_rspace%0d", tag, k), 64'(m_rv_cyc[r0+k] - m_rv_cyc[r0+k-1]), 64'd16);
    end
  endtask

  vec_t vecs [5];

  initial begin
    int acc, acc2, d0, a0, bad;
    bit ok;
    vec_t vr;

    vecs[0] = '{rw:1'b1, addr:7'h15, len:4'd1, w0:8'hA5, w1:8'h5A, sw:24'h0,
                nb:16, lat:33, acks:1, nrv:0, bits:64'h95A5, oe:64'hFFFF, rdata:8'h00};
    vecs[1] = '{rw:1'b0, addr:7'h03, len:4'd1, w0:8'h00, w1:8'hFF, sw:24'h3C0000,
                nb:16, lat:33, acks:0, nrv:1, bits:64'h0300, oe:64'hFF00, rdata:8'h3C};
    vecs[2] = '{rw:1'b1, addr:7'h00, len:4'd0, w0:8'h5A, w1:8'h00, sw:24'h0,
                nb:16, lat:33, acks:1, nrv:0, bits:64'h805A, oe:64'hFFFF, rdata:8'h3C};
    vecs[3] = '{rw:1'b0, addr:7'h2A, len:4'd3, w0:8'h00, w1:8'h00, sw:24'h112233,
                nb:32, lat:65, acks:0, nrv:3, bits:64'h2A000000, oe:64'hFF000000, rdata:8'h33};
    vecs[4] = '{rw:1'b1, addr:7'h41, len:4'd2, w0:8'hA5, w1:8'h3C, sw:24'h0,
                nb:24, lat:49, acks:2, nrv:0, bits:64'hC1A53C, oe:64'hFFFFFF, rdata:8'h33};
    for (int i = 0; i < 4; i++) begin
      s_words[i]  = '0;
      s3_words[i] = '0;
    end

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({wdata_ack, rdata, rdata_valid, busy, done, spi_en, spi_clk, spi_in, spi_oe}), 64'd0);
    check("reset_outputs_div3",
          64'({wdata_ack3, rdata3, rdata_valid3, busy3, done3, spi_en3, spi_clk3, spi_in3, spi_oe3}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Starts during an active frame are ignored; a start held in the done
    // cycle launches the next frame with SPI_EN low for one cycle.
    s_words[0] = 8'h81;
    @(negedge clk);
    rw = 1'b0; addr = 7'h10; len = 4'd1; start = 1'b1;
    #1;
    d0 = m_dones; a0 = m_acks;
    @(posedge clk);
    #1;
    acc = m_cyc; start = 1'b0;
    repeat (4) @(negedge clk);
    rw = 1'b1; start = 1'b1;
    @(negedge clk);
    check("ign5_busy", 64'(busy), 64'd1);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("ign20_busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(1'b0, "ign", ok);
    check("b2b_en_low", 64'({spi_en, busy}), 64'd0);
    rw = 1'b1; addr = 7'h01; len = 4'd1; wdata = 8'hC3; start = 1'b1;
    #1;
    check("ign_latency", 64'(m_done_cyc - acc), 64'd33);
    check("ign_dones", 64'(m_dones - d0), 64'd1);
    check("ign_no_ack", 64'(m_acks - a0), 64'd0);
    check("ign_rdata", 64'(rdata), 64'h81);
    @(posedge clk);
    #1;
    acc2 = m_cyc; start = 1'b0;
    @(negedge clk);
    check("b2b_en_high", 64'({spi_en, busy}), 64'd3);
    wait_done(1'b0, "b2b", ok);
    #1;
    check("b2b_latency", 64'(m_done_cyc - acc2), 64'd33);
    check("b2b_spi_in", m_bits & 64'hFFFF, 64'h81C3);

    // Reset in the middle of a write
    @(negedge clk);
    rw = 1'b1; addr = 7'h2B; len = 4'd1; wdata = 8'h66; start = 1'b1;
    #1;
    d0 = m_dones;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_en", 64'(spi_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          64'({wdata_ack, rdata, rdata_valid, busy, done, spi_en, spi_clk, spi_in, spi_oe}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset_no_done", 64'(m_dones - d0), 64'd0);
    vr = '{rw:1'b0, addr:7'h55, len:4'd1, w0:8'h00, w1:8'h00, sw:24'hE70000,
           nb:16, lat:33, acks:0, nrv:1, bits:64'h5500, oe:64'hFF00, rdata:8'hE7};
    run_vec(vr, "post_reset");

    // CLK_DIV=3 instance: read with len=0
    s3_words[0] = 8'h96;
    @(negedge clk);
    rw = 1'b0; addr = 7'h33; len = 4'd0; start3 = 1'b1;
    #1;
    d0 = m3_rv;
    @(posedge clk);
    #1;
    acc = m_cyc; start3 = 1'b0;
    bad = 0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      if (spi_clk3 !== (((i / 3) % 2) == 1)) bad++;
      if (spi_en3 !== 1'b1) bad++;
    end
    check("div3_clk_pattern", 64'(bad), 64'd0);
    wait_done(1'b1, "div3", ok);
    #1;
    check("div3_latency", 64'(m3_done_cyc - acc), 64'd97);
    check("div3_rdata", 64'(rdata3), 64'h96);
    check("div3_rvalids", 64'(m3_rv - d0), 64'd1);
    check("div3_dones", 64'(m3_dones), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
